// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory port between the multi-cycle core and a debug/loader requester.
// A debug access stalls the core for one DBG cycle, then an ACK cycle returns the port to the core.
module mem_arbiter #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] core_adr,
   input  logic [DW-1:0] core_wd,
   input  logic          core_we,
   output logic [DW-1:0] core_rd,
   output logic          core_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_adr,
   input  logic [DW-1:0] dbg_wd,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rdata,
   input  logic          dbg_halt,
   output logic          dbg_halted,
   output logic [CW-1:0] stall_cnt,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wd,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rd
);

   typedef enum logic [1:0] {
      S_CORE = 2'd0,
      S_DBG  = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t state, state_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_CORE;
      end else begin
         state <= state_next;
      end
   end

   // ACK always yields one core-owned cycle, so a held request cannot starve the core.
   always_comb begin
      state_next = state;
      case (state)
         S_CORE:  state_next = dbg_req ? S_DBG : S_CORE;
         S_DBG:   state_next = S_ACK;
         S_ACK:   state_next = S_CORE;
         default: state_next = S_CORE;
      endcase
   end

   always_comb begin
      core_stall = (state == S_DBG) | dbg_halted;
      core_rd    = mem_rd;
      mem_adr    = core_adr;
      mem_wd     = core_wd;
      mem_we     = core_we & ~core_stall & ~reset;
      if (state == S_DBG) begin
         mem_adr = dbg_adr;
         mem_wd  = dbg_wd;
         mem_we  = dbg_we & ~reset;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dbg_ack    <= 1'b0;
         dbg_rdata  <= '0;
         dbg_halted <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         dbg_ack    <= (state == S_DBG);
         dbg_halted <= dbg_halt;
         if ((state == S_DBG) && !dbg_we) begin
            dbg_rdata <= mem_rd;
         end
         if (core_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified instruction/data memory port between the multi-cycle MIPS core and a debug/loader requester. The core owns the memory by default. A debug access freezes the core for exactly one cycle through a global stall, performs the access, then hands the memory back. The block sits between the core's `adr`/`b`/`memwrite`/`readData` signals and the memory, and also provides a halt mode used for program loading.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- CW, 16, stall-counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- core_adr  in  AW  core memory address
- core_wd  in  DW  core write data
- core_we  in  1  core write enable
- core_rd  out  DW  read data to core; equals mem_rd
- core_stall  out  1  freezes every core register (PC, IR, regfile, FSM) while high
- dbg_req  in  1  debug access request; level, held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read; stable while dbg_req high
- dbg_adr  in  AW  debug address; stable while dbg_req high
- dbg_wd  in  DW  debug write data; stable while dbg_req high
- dbg_ack  out  1  one-cycle completion pulse, registered
- dbg_rdata  out  DW  read data, registered; valid while dbg_ack is high and held until the next access
- dbg_halt  in  1  level request to hold the core stalled
- dbg_halted  out  1  core is held; registered copy of dbg_halt
- stall_cnt  out  CW  saturating count of cycles with core_stall high
- mem_adr  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  DW  memory read data; combinational read, write at clk edge

## Operation
- State machine, 3 states:
  - CORE: core owns memory. If dbg_req=1 at the clock edge, go to DBG; otherwise stay in CORE.
  - DBG: debug owns memory. mem_adr=dbg_adr, mem_wd=dbg_wd, mem_we=dbg_we & ~reset. dbg_rdata <= mem_rd when dbg_we=0; dbg_rdata unchanged on a write. Always go to ACK.
  - ACK: dbg_ack=1. Core owns memory. dbg_req is ignored in this state. Go to CORE.
- In CORE and ACK: mem_adr=core_adr, mem_wd=core_wd, mem_we=core_we & ~core_stall & ~reset.
- core_rd = mem_rd at all times.
- core_stall = (state==DBG) | dbg_halted, decoded from registers only.
- A core write that is blocked by the stall is not lost. The frozen core re-presents it on its next unstalled cycle.
- dbg_halted <= dbg_halt every cycle. While halted, the core makes no accesses, and debug accesses run DBG→ACK→CORE back-to-back (3 cycles each).
- When not halted, every debug access is followed by at least one core-owned cycle (ACK). The core therefore cannot be starved.
- stall_cnt increments by 1 on every cycle where core_stall=1. It saturates at 2^CW−1 and is cleared only by reset.

## Timing
- Reset values: state=CORE, core_stall=0, dbg_ack=0, dbg_rdata=0, dbg_halted=0, stall_cnt=0, mem_we=0 during the reset cycle.
- Debug latency: dbg_req rises in cycle n (state CORE) → DBG in n+1 → dbg_ack and dbg_rdata valid in n+2.
- Requester rule: drop dbg_req, or present a new request, in the cycle after dbg_ack. If dbg_req is still high in the CORE cycle that follows ACK, it is treated as a new request.
- Reset during DBG: no write reaches memory, no ack is issued, and the request is abandoned. Reset during ACK: the ack is dropped.
- If dbg_halt and dbg_req rise in the same cycle, both take effect: the stall is contiguous from n+1.
- If dbg_halt is deasserted during DBG, core_stall stays high through DBG because state==DBG. The core resumes in ACK.

## Test plan
- Reset, then core writes 0x1234 to 0x40 and reads it back. Required: core_stall=0 throughout, core_rd=0x1234, dbg_ack never asserted, stall_cnt=0.
- Debug write of 0xDEADBEEF to 0x80 while the core runs. Required: core_stall high for exactly 1 cycle, dbg_ack 2 cycles after dbg_req, core later reads 0xDEADBEEF, stall_cnt=1.
- Debug read of 0x80 while the core asserts core_we to 0x84 in the DBG cycle. Required: dbg_rdata=0xDEADBEEF with dbg_ack, no write to 0x84 during DBG, the core write lands in the ACK cycle.
- dbg_halt=1, then 4 back-to-back debug writes to 0x0..0xC, then dbg_halt=0. Required: core_stall continuously high, one ack every 3 cycles, memory contents correct, and stall_cnt equal to the number of halted cycles.
- Assert reset in the DBG cycle of a debug write to 0x100. Required: 0x100 unchanged, no dbg_ack, all outputs at reset values on the next cycle.
- Hold dbg_halt for 2^CW+5 cycles with CW=4. Required: stall_cnt saturates at 15.
